// File: rtl/mgmt_smbus_ch_ctrl_pkg.sv
// Shared types and defaults for the SMBus channel supervisor: LTPI link states,
// the per-channel supervisor state encoding and default timing constants.
package mgmt_smbus_ch_ctrl_pkg;

    typedef enum logic [3:0] {
        link_detect_st    = 4'd0,
        link_speed_st     = 4'd1,
        advertise_st      = 4'd2,
        configure_st      = 4'd3,
        accept_st         = 4'd4,
        operational_st    = 4'd5,
        link_lost_st      = 4'd6
    } link_state_t;

    typedef enum logic [2:0] {
        CH_OFF      = 3'd0,
        CH_RESET    = 3'd1,
        CH_ACTIVE   = 3'd2,
        CH_RECOVER  = 3'd3,
        CH_DISABLED = 3'd4
    } smbus_ch_state_t;

    localparam int SMBUS_STABLE_CYCLES    = 64;
    localparam int SMBUS_RST_PULSE_CYCLES = 16;

endpackage

// File: rtl/mgmt_smbus_ch_ctrl_if.sv
// Per-channel control/status bundle between the supervisor and its consumers.
interface mgmt_smbus_ch_ctrl_if #(
    parameter int NUM_CH = 6,
    parameter int CNT_W  = 16
);
    // No valid/ready here: ch_enable is a level, soft_rst is level or pulse, relay_timeout
    // and retry_clear are single-cycle pulses; every status output is a registered level.
    logic [NUM_CH-1:0]            ch_enable;
    logic [NUM_CH-1:0]            soft_rst;
    logic [NUM_CH-1:0]            relay_timeout;
    logic [NUM_CH-1:0]            retry_clear;
    logic [NUM_CH-1:0]            relay_rst_n;
    logic [NUM_CH-1:0]            echo_rst;
    logic [NUM_CH-1:0][2:0]       ch_state;
    logic [NUM_CH-1:0]            ch_disabled;
    logic [NUM_CH-1:0][CNT_W-1:0] timeout_cnt;

    modport master (
        output ch_enable, soft_rst, relay_timeout, retry_clear,
        input  relay_rst_n, echo_rst, ch_state, ch_disabled, timeout_cnt
    );

    modport slave (
        input  ch_enable, soft_rst, relay_timeout, retry_clear,
        output relay_rst_n, echo_rst, ch_state, ch_disabled, timeout_cnt
    );

endinterface

// File: rtl/mgmt_smbus_ch_ctrl_fsm.sv
// One channel of the supervisor: reset/recovery FSM, reset-pulse counter,
// bounded retry count with auto-disable, and saturating timeout statistics.
module mgmt_smbus_ch_ctrl_fsm
    import mgmt_smbus_ch_ctrl_pkg::*;
#(
    parameter int RST_PULSE_CYCLES = SMBUS_RST_PULSE_CYCLES,
    parameter int MAX_RETRY        = 3,
    parameter int CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             link_up,
    input  logic             ch_enable,
    input  logic             soft_rst,
    input  logic             relay_timeout,
    input  logic             retry_clear,
    output smbus_ch_state_t  state,
    output logic             relay_rst_n,
    output logic             echo_rst,
    output logic             disabled,
    output logic [CNT_W-1:0] timeout_cnt
);
    localparam int PW = $clog2(RST_PULSE_CYCLES + 1);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(RST_PULSE_CYCLES);

    smbus_ch_state_t  state_q, state_d;
    logic [PW-1:0]    pulse_q, pulse_d;
    logic [3:0]       retry_q, retry_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             relay_rst_n_q, relay_rst_n_d;
    logic             echo_rst_q, echo_rst_d;
    logic             disabled_q, disabled_d;
    logic             drop;
    logic             take_tmo;
    logic [3:0]       retry_inc;

    always_comb begin
        state_d   = state_q;
        pulse_d   = pulse_q;
        retry_d   = retry_q;
        tcnt_d    = tcnt_q;
        drop      = !link_up || !ch_enable;
        retry_inc = retry_q + 4'd1;
        take_tmo  = 1'b0;
        unique case (state_q)
            CH_OFF: begin
                if (!drop) begin
                    state_d = CH_RESET;
                    pulse_d = PULSE_LOAD;
                end
            end
            CH_RESET, CH_RECOVER: begin
                if (drop) begin
                    state_d = CH_OFF;
                end else if (soft_rst) begin
                    pulse_d = PULSE_LOAD;
                end else begin
                    pulse_d = pulse_q - PW'(1);
                    if (pulse_q <= PW'(1)) state_d = CH_ACTIVE;
                end
            end
            CH_ACTIVE: begin
                // A timeout is counted unless retry_clear or soft_rst consumed the cycle;
                // a link/enable drop still lets the statistic record it.
                take_tmo = relay_timeout && (drop || (!retry_clear && !soft_rst));
                if (drop) begin
                    state_d = CH_OFF;
                end else if (!retry_clear) begin
                    if (soft_rst) begin
                        state_d = CH_RESET;
                        pulse_d = PULSE_LOAD;
                    end else if (relay_timeout) begin
                        retry_d = retry_inc;
                        if (retry_inc == 4'(MAX_RETRY)) begin
                            state_d = CH_DISABLED;
                        end else begin
                            state_d = CH_RECOVER;
                            pulse_d = PULSE_LOAD;
                        end
                    end
                end
            end
            CH_DISABLED: begin
                if (!ch_enable || retry_clear) state_d = CH_OFF;
            end
            default: state_d = CH_OFF;
        endcase
        if (!ch_enable || retry_clear) retry_d = '0;
        if (take_tmo && (tcnt_q != '1)) tcnt_d = tcnt_q + CNT_W'(1);
        relay_rst_n_d = (state_d == CH_ACTIVE);
        echo_rst_d    = !relay_rst_n_d || relay_timeout;
        disabled_d    = (state_d == CH_DISABLED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= CH_OFF;
            pulse_q       <= '0;
            retry_q       <= '0;
            tcnt_q        <= '0;
            relay_rst_n_q <= 1'b0;
            echo_rst_q    <= 1'b1;
            disabled_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pulse_q       <= pulse_d;
            retry_q       <= retry_d;
            tcnt_q        <= tcnt_d;
            relay_rst_n_q <= relay_rst_n_d;
            echo_rst_q    <= echo_rst_d;
            disabled_q    <= disabled_d;
        end
    end

    assign state       = state_q;
    assign relay_rst_n = relay_rst_n_q;
    assign echo_rst    = echo_rst_q;
    assign disabled    = disabled_q;
    assign timeout_cnt = tcnt_q;

endmodule

// File: rtl/mgmt_smbus_ch_ctrl.sv
// SMBus tunnel control plane: debounced link qualifier shared by NUM_CH
// independent channel supervisors.
module mgmt_smbus_ch_ctrl
    import mgmt_smbus_ch_ctrl_pkg::*;
#(
    parameter int NUM_CH           = 6,
    parameter int STABLE_CYCLES    = SMBUS_STABLE_CYCLES,
    parameter int RST_PULSE_CYCLES = SMBUS_RST_PULSE_CYCLES,
    parameter int MAX_RETRY        = 3,
    parameter int CNT_W            = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  link_state_t           local_link_state,
    input  link_state_t           remote_link_state,
    output logic                  link_up,
    mgmt_smbus_ch_ctrl_if.slave   ch_bus
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);

    logic [SW-1:0] stab_q, stab_d;
    logic          link_up_q, link_up_d;
    logic          both_op;

    logic [NUM_CH-1:0]            relay_rst_n_w;
    logic [NUM_CH-1:0]            echo_rst_w;
    logic [NUM_CH-1:0]            disabled_w;
    logic [NUM_CH-1:0][2:0]       ch_state_w;
    logic [NUM_CH-1:0][CNT_W-1:0] timeout_cnt_w;

    // link_up needs STABLE_CYCLES consecutive operational samples; one bad sample restarts the run.
    always_comb begin
        both_op = (local_link_state == operational_st) && (remote_link_state == operational_st);
        stab_d  = '0;
        if (both_op) stab_d = (stab_q == SW'(STABLE_CYCLES)) ? stab_q : stab_q + SW'(1);
        link_up_d = both_op && (stab_d == SW'(STABLE_CYCLES));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stab_q    <= '0;
            link_up_q <= 1'b0;
        end else begin
            stab_q    <= stab_d;
            link_up_q <= link_up_d;
        end
    end

    assign link_up = link_up_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        smbus_ch_state_t st;

        mgmt_smbus_ch_ctrl_fsm #(
            .RST_PULSE_CYCLES (RST_PULSE_CYCLES),
            .MAX_RETRY        (MAX_RETRY),
            .CNT_W            (CNT_W)
        ) u_fsm (
            .clk           (clk),
            .rst_n         (reset_n),
            .link_up       (link_up_q),
            .ch_enable     (ch_bus.ch_enable[i]),
            .soft_rst      (ch_bus.soft_rst[i]),
            .relay_timeout (ch_bus.relay_timeout[i]),
            .retry_clear   (ch_bus.retry_clear[i]),
            .state         (st),
            .relay_rst_n   (relay_rst_n_w[i]),
            .echo_rst      (echo_rst_w[i]),
            .disabled      (disabled_w[i]),
            .timeout_cnt   (timeout_cnt_w[i])
        );

        assign ch_state_w[i] = st;
    end

    assign ch_bus.relay_rst_n = relay_rst_n_w;
    assign ch_bus.echo_rst    = echo_rst_w;
    assign ch_bus.ch_state    = ch_state_w;
    assign ch_bus.ch_disabled = disabled_w;
    assign ch_bus.timeout_cnt = timeout_cnt_w;

endmodule

// File: tb/tb_mgmt_smbus_ch_ctrl.sv
// Bench for mgmt_smbus_ch_ctrl: directed vector table, hand-written corner
// sequences, then randomized traffic against a behavioural reference model.
module tb_mgmt_smbus_ch_ctrl;
    import mgmt_smbus_ch_ctrl_pkg::*;

    localparam int NUM_CH = 6;
    localparam int STABLE = 64;
    localparam int RSTP   = 16;
    localparam int MAXR   = 3;
    localparam int CNT_W  = 4;
    localparam int W      = 1 + NUM_CH * (1 + 1 + 3 + 1 + CNT_W);

    localparam logic [2:0] ST_OFF = 3'd0, ST_RESET = 3'd1, ST_ACTIVE = 3'd2;
    localparam logic [2:0] ST_RECOVER = 3'd3, ST_DISABLED = 3'd4;
    localparam int S_OFF = 0, S_RESET = 1, S_ACTIVE = 2, S_RECOVER = 3, S_DISABLED = 4;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset_n;
    link_state_t local_link_state, remote_link_state;
    logic        link_up;

    always #5 clk = ~clk;

    mgmt_smbus_ch_ctrl_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) ch_bus ();

    mgmt_smbus_ch_ctrl #(
        .NUM_CH(NUM_CH), .STABLE_CYCLES(STABLE), .RST_PULSE_CYCLES(RSTP),
        .MAX_RETRY(MAXR), .CNT_W(CNT_W)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .local_link_state  (local_link_state),
        .remote_link_state (remote_link_state),
        .link_up           (link_up),
        .ch_bus            (ch_bus)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_run;
    bit m_link;
    int m_st[NUM_CH], m_held[NUM_CH], m_retry[NUM_CH], m_tcnt[NUM_CH];
    bit m_rrst[NUM_CH], m_echo[NUM_CH];

    task automatic model_reset();
        m_run = 0;
        m_link = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_st[c] = S_OFF; m_held[c] = 0; m_retry[c] = 0; m_tcnt[c] = 0;
            m_rrst[c] = 0; m_echo[c] = 1;
        end
    endtask

    // Advance the model across one clock edge using the inputs currently driven.
    task automatic model_step();
        bit both, lk, en, sr, to, rc, drop;
        int ns;
        both = (local_link_state == operational_st) && (remote_link_state == operational_st);
        lk = m_link;
        for (int c = 0; c < NUM_CH; c++) begin
            en = ch_bus.ch_enable[c]; sr = ch_bus.soft_rst[c];
            to = ch_bus.relay_timeout[c]; rc = ch_bus.retry_clear[c];
            drop = !lk || !en;
            ns = m_st[c];
            case (m_st[c])
                S_OFF: if (!drop) begin ns = S_RESET; m_held[c] = 1; end
                S_RESET, S_RECOVER: begin
                    if (drop) ns = S_OFF;
                    else if (sr) m_held[c] = 1;
                    else if (m_held[c] == RSTP) ns = S_ACTIVE;
                    else m_held[c]++;
                end
                S_ACTIVE: begin
                    if (to && (drop || (!rc && !sr)) && m_tcnt[c] < (1 << CNT_W) - 1) m_tcnt[c]++;
                    if (drop) ns = S_OFF;
                    else if (!rc && sr) begin ns = S_RESET; m_held[c] = 1; end
                    else if (!rc && to) begin
                        m_retry[c]++;
                        ns = (m_retry[c] == MAXR) ? S_DISABLED : S_RECOVER;
                        m_held[c] = 1;
                    end
                end
                default: if (!en || rc) ns = S_OFF;
            endcase
            if (!en || rc) m_retry[c] = 0;
            m_st[c]   = ns;
            m_rrst[c] = (ns == S_ACTIVE);
            m_echo[c] = !m_rrst[c] || to;
        end
        m_run  = both ? m_run + 1 : 0;
        m_link = both && (m_run >= STABLE);
    endtask

    function automatic logic [W-1:0] model_pack();
        logic [NUM_CH-1:0] r, e, d;
        logic [NUM_CH-1:0][2:0] s;
        logic [NUM_CH-1:0][CNT_W-1:0] t;
        for (int c = 0; c < NUM_CH; c++) begin
            r[c] = m_rrst[c]; e[c] = m_echo[c]; d[c] = (m_st[c] == S_DISABLED);
            s[c] = 3'(m_st[c]); t[c] = CNT_W'(m_tcnt[c]);
        end
        return {m_link, r, e, s, d, t};
    endfunction

    function automatic logic [W-1:0] dut_pack();
        return {link_up, ch_bus.relay_rst_n, ch_bus.echo_rst, ch_bus.ch_state,
                ch_bus.ch_disabled, ch_bus.timeout_cnt};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] tmo, input logic [NUM_CH-1:0] sr,
                         input logic [NUM_CH-1:0] rc);
        ch_bus.relay_timeout = tmo; ch_bus.soft_rst = sr; ch_bus.retry_clear = rc;
        cycle();
        ch_bus.relay_timeout = '0; ch_bus.soft_rst = '0; ch_bus.retry_clear = '0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    function automatic link_state_t ls(input bit op);
        return op ? operational_st : link_lost_st;
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        string          name;
        bit             do_rst;
        int             cycles;
        bit             loc_op;
        bit             rem_op;
        bit             exp_link;
        logic [NUM_CH-1:0] exp_rrst;
        logic [2:0]     exp_st0;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [NUM_CH-1:0] en_r;
        int bit_i;

        vecs[0] = '{"bring_pre",   1, 63, 1, 1, 0, 6'h00, ST_OFF};
        vecs[1] = '{"bring_link",  0,  1, 1, 1, 1, 6'h00, ST_OFF};
        vecs[2] = '{"bring_rst",   0,  1, 1, 1, 1, 6'h00, ST_RESET};
        vecs[3] = '{"bring_hold",  0, 15, 1, 1, 1, 6'h00, ST_RESET};
        vecs[4] = '{"bring_act",   0,  1, 1, 1, 1, 6'h3f, ST_ACTIVE};
        vecs[5] = '{"glitch_a",    1, 40, 1, 1, 0, 6'h00, ST_OFF};
        vecs[6] = '{"glitch_drop", 0,  1, 1, 0, 0, 6'h00, ST_OFF};
        vecs[7] = '{"glitch_b",    0, 63, 1, 1, 0, 6'h00, ST_OFF};
        vecs[8] = '{"glitch_rise", 0,  1, 1, 1, 1, 6'h00, ST_OFF};
        vecs[9] = '{"glitch_rst",  0,  1, 1, 1, 1, 6'h00, ST_RESET};

        reset_n = 1'b0;
        local_link_state = operational_st;
        remote_link_state = operational_st;
        ch_bus.ch_enable = '1;
        ch_bus.soft_rst = '0; ch_bus.relay_timeout = '0; ch_bus.retry_clear = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_link_up", 64'(link_up), 64'd0);
        check("rst_relay_rst_n", 64'(ch_bus.relay_rst_n), 64'h00);
        check("rst_echo_rst", 64'(ch_bus.echo_rst), 64'h3f);
        check("rst_ch_state", 64'(ch_bus.ch_state), 64'd0);
        check("rst_ch_disabled", 64'(ch_bus.ch_disabled), 64'd0);
        check("rst_timeout_cnt", 64'(ch_bus.timeout_cnt), 64'd0);

        for (int v = 0; v < 10; v++) begin
            local_link_state  = ls(vecs[v].loc_op);
            remote_link_state = ls(vecs[v].rem_op);
            if (vecs[v].do_rst) apply_reset();
            run(vecs[v].cycles);
            check({vecs[v].name, "_link"}, 64'(link_up), 64'(vecs[v].exp_link));
            check({vecs[v].name, "_rrst"}, 64'(ch_bus.relay_rst_n), 64'(vecs[v].exp_rrst));
            check({vecs[v].name, "_st0"}, 64'(ch_bus.ch_state[0]), 64'(vecs[v].exp_st0));
        end
        run(16);
        check("glitch_active", 64'(ch_bus.relay_rst_n), 64'h3f);

        // Retry exhaustion on ch2: two recover holds, then DISABLED.
        for (int k = 1; k <= 2; k++) begin
            pulse(6'b000100, '0, '0);
            check("rx_recover", 64'(ch_bus.ch_state[2]), 64'(ST_RECOVER));
            check("rx_tcnt", 64'(ch_bus.timeout_cnt[2]), 64'(k));
            check("rx_echo", 64'(ch_bus.echo_rst[2]), 64'd1);
            run(15);
            check("rx_hold", 64'(ch_bus.ch_state[2]), 64'(ST_RECOVER));
            run(1);
            check("rx_back", 64'(ch_bus.ch_state[2]), 64'(ST_ACTIVE));
        end
        pulse(6'b000100, '0, '0);
        check("rx_disabled_st", 64'(ch_bus.ch_state[2]), 64'(ST_DISABLED));
        check("rx_disabled", 64'(ch_bus.ch_disabled), 64'b000100);
        check("rx_tcnt3", 64'(ch_bus.timeout_cnt[2]), 64'd3);
        check("rx_others", 64'(ch_bus.relay_rst_n), 64'b111011);
        pulse('0, '0, 6'b000100);
        check("rx_clr_off", 64'(ch_bus.ch_state[2]), 64'(ST_OFF));
        run(1);
        check("rx_clr_reset", 64'(ch_bus.ch_state[2]), 64'(ST_RESET));
        run(15);
        check("rx_clr_hold", 64'(ch_bus.ch_state[2]), 64'(ST_RESET));
        run(1);
        check("rx_clr_active", 64'(ch_bus.relay_rst_n), 64'h3f);

        // soft_rst and relay_timeout together on ch1: soft_rst wins, nothing counted.
        pulse(6'b000010, 6'b000010, '0);
        check("sr_tmo_state", 64'(ch_bus.ch_state[1]), 64'(ST_RESET));
        check("sr_tmo_tcnt", 64'(ch_bus.timeout_cnt[1]), 64'd0);
        run(16);
        check("sr_tmo_active", 64'(ch_bus.ch_state[1]), 64'(ST_ACTIVE));
        pulse(6'b000010, '0, '0);
        run(16);
        pulse(6'b000010, '0, '0);
        check("sr_retry_kept", 64'(ch_bus.ch_state[1]), 64'(ST_RECOVER));
        check("sr_tcnt2", 64'(ch_bus.timeout_cnt[1]), 64'd2);
        run(16);
        pulse('0, '0, 6'b000010);

        // Link drop in the middle of ch0 RECOVER; retry count must survive.
        pulse(6'b000001, '0, '0);
        run(5);
        local_link_state = link_lost_st;
        cycle();
        check("drop_link", 64'(link_up), 64'd0);
        local_link_state = operational_st;
        cycle();
        check("drop_off", 64'(ch_bus.ch_state[0]), 64'(ST_OFF));
        check("drop_rrst", 64'(ch_bus.relay_rst_n[0]), 64'd0);
        check("drop_echo", 64'(ch_bus.echo_rst[0]), 64'd1);
        run(64);
        check("drop_relink", 64'(link_up), 64'd1);
        run(17);
        check("drop_reactive", 64'(ch_bus.ch_state[0]), 64'(ST_ACTIVE));
        pulse(6'b000001, '0, '0);
        run(16);
        pulse(6'b000001, '0, '0);
        check("drop_retry_kept", 64'(ch_bus.ch_state[0]), 64'(ST_DISABLED));
        pulse('0, '0, 6'b000001);
        run(17);

        // Saturate ch3 statistics, then async reset in the middle of RESET.
        for (int k = 0; k < 16; k++) begin
            pulse(6'b001000, '0, '0);
            run(16);
            pulse('0, '0, 6'b001000);
        end
        check("sat_tcnt", 64'(ch_bus.timeout_cnt[3]), 64'd15);
        pulse('0, 6'b001000, '0);
        run(4);
        check("async_pre_state", 64'(ch_bus.ch_state[3]), 64'(ST_RESET));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_link_up", 64'(link_up), 64'd0);
        check("async_rrst", 64'(ch_bus.relay_rst_n), 64'h00);
        check("async_echo", 64'(ch_bus.echo_rst), 64'h3f);
        check("async_state", 64'(ch_bus.ch_state), 64'd0);
        check("async_disabled", 64'(ch_bus.ch_disabled), 64'd0);
        check("async_tcnt", 64'(ch_bus.timeout_cnt), 64'd0);

        // Randomized traffic against the reference model.
        en_r = '1;
        ch_bus.ch_enable = en_r;
        apply_reset();
        for (int n = 0; n < 4000; n++) begin
            local_link_state  = ls($urandom_range(0, 199) != 0);
            remote_link_state = ls($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 59) == 0) begin
                bit_i = $urandom_range(0, NUM_CH - 1);
                en_r[bit_i] = ~en_r[bit_i];
            end
            ch_bus.ch_enable = en_r;
            for (int c = 0; c < NUM_CH; c++) begin
                ch_bus.soft_rst[c]      = ($urandom_range(0, 119) == 0);
                ch_bus.relay_timeout[c] = ($urandom_range(0, 29) == 0);
                ch_bus.retry_clear[c]   = ($urandom_range(0, 99) == 0);
            end
            cycle();
            exp_q.push_back(model_pack());
            check("rand_cycle", 64'(dut_pack()), 64'(exp_q.pop_front()));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mgmt_smbus_ch_ctrl.md
Name: mgmt_smbus_ch_ctrl

Overview:
Parametrised per-channel SMBus relay supervisor. It is the next-generation control plane for the LTPI SMBus tunnel, sitting between the link-state machines and the per-channel smbus relay and echo instances.
It replaces the single "both links operational" reset gate with three things: a debounced link qualifier, a per-channel reset/recovery FSM with a bounded retry count and auto-disable, and saturating timeout statistics.
Channel count is generic (1..16) instead of a fixed 6.

Parameters:
NUM_CH, 6, number of SMBus channels supervised; legal range 1..16
STABLE_CYCLES, 64, consecutive cycles both link states must be operational_st before link_up asserts; minimum 1
RST_PULSE_CYCLES, 16, cycles relay reset is held on each (re)start; minimum 1
MAX_RETRY, 3, relay timeouts tolerated before a channel is disabled; legal range 1..15
CNT_W, 16, width of the per-channel timeout statistics counter

Ports:
clk  in  1  system clock (60 MHz)
reset_n  in  1  reset; asynchronous, active-low
local_link_state  in  link_state_t  local LTPI link state
remote_link_state  in  link_state_t  remote LTPI link state
ch_enable  in  NUM_CH  per-channel enable (config capability)
soft_rst  in  NUM_CH  per-channel soft reset request, level or pulse
relay_timeout  in  NUM_CH  one-cycle pulse from the relay's smbus_timeout
retry_clear  in  NUM_CH  one-cycle pulse; clears the retry count and releases DISABLED
link_up  out  1  debounced link qualifier
relay_rst_n  out  NUM_CH  active-low reset to each smbus relay
echo_rst  out  NUM_CH  active-high reset to each smbus_echo
ch_state  out  NUM_CH x 3  current FSM state encoding
ch_disabled  out  NUM_CH  channel parked in DISABLED
timeout_cnt  out  NUM_CH x CNT_W  saturating count of timeouts taken in ACTIVE

Behaviour:
- Reset values (reset_n low):
  - link_up=0, relay_rst_n=0, echo_rst=1, ch_state=OFF, ch_disabled=0, timeout_cnt=0.
  - Internal retry_cnt=0, pulse counter=0.
- Outputs: all outputs are registered.
- Link qualifier:
  - both_op = (local == operational_st) && (remote == operational_st).
  - stab_cnt increments while both_op, saturates at STABLE_CYCLES, and clears to 0 on the first cycle both_op is low.
  - link_up = 1 when stab_cnt has reached STABLE_CYCLES and both_op is high. Result: link_up rises on the STABLE_CYCLES-th edge after both_op first samples high.
  - link_up falls on the edge after both_op drops (1-cycle latency).
- Per-channel FSM states: OFF=0, RESET=1, ACTIVE=2, RECOVER=3, DISABLED=4.
  - OFF: relay_rst_n=0. Enter RESET when link_up && ch_enable; load pulse counter with RST_PULSE_CYCLES.
  - RESET: relay_rst_n=0; pulse counter decrements each cycle. At 0 go to ACTIVE; relay_rst_n=1 from the first ACTIVE cycle. Latency from link_up rise to relay_rst_n rise is RST_PULSE_CYCLES+1 cycles.
  - ACTIVE: relay_rst_n=1.
  - RECOVER: identical to RESET (hold RST_PULSE_CYCLES), then ACTIVE. retry_cnt is not cleared.
  - DISABLED: relay_rst_n=0, ch_disabled=1. relay_timeout and soft_rst are ignored.
- ACTIVE event priority, highest first:
  1. !link_up or !ch_enable -> OFF.
  2. retry_clear -> retry_cnt=0, stay ACTIVE.
  3. soft_rst -> RESET, pulse counter reloaded; retry_cnt unchanged.
  4. relay_timeout -> retry_cnt+1 and timeout_cnt+1. If the new retry_cnt == MAX_RETRY go to DISABLED, else RECOVER.
- Reset-phase interruptions (RESET/RECOVER):
  - !link_up or !ch_enable aborts to OFF.
  - soft_rst reloads the pulse counter, extending the hold.
- DISABLED exits:
  - !ch_enable -> OFF, retry_cnt=0.
  - retry_clear -> OFF, retry_cnt=0; the channel re-enters RESET next cycle if link_up.
  - A link drop does not exit DISABLED.
- Counters:
  - retry_cnt is also cleared whenever ch_enable is low.
  - timeout_cnt saturates at all-ones and is cleared only by reset_n.
- echo_rst: registered (!relay_rst_n_next || relay_timeout), so the echo is reset during every relay reset and on each timeout pulse.
- Timeout in the same cycle as a link drop: the link drop wins; timeout_cnt still increments, retry_cnt does not.
- Channels are fully independent; no shared arbitration.

Decomposition:
- ltpi_pkg gains smbus_ch_state_t (3-bit enum: OFF/RESET/ACTIVE/RECOVER/DISABLED) and the default constants SMBUS_STABLE_CYCLES and SMBUS_RST_PULSE_CYCLES.
- One sub-module, mgmt_smbus_ch_fsm: the per-channel FSM, pulse counter, retry_cnt and timeout_cnt. It is generated NUM_CH times.
- The link qualifier stays in the top level.

Test Plan:
- Link bring-up: both states operational_st from cycle 0, STABLE_CYCLES=64, RST_PULSE_CYCLES=16, ch_enable=all -> link_up=1 at cycle 64; relay_rst_n=all-ones at cycle 81; ch_state=2.
- Glitch debounce: remote drops out of operational_st for 1 cycle at cycle 40 -> link_up stays 0 until cycle 105; relays stay in reset.
- Retry exhaustion: MAX_RETRY=3, three relay_timeout pulses on ch2 in ACTIVE -> two RECOVER holds of 16 cycles each, then ch_disabled[2]=1, timeout_cnt[2]=3; other channels unaffected. retry_clear[2] -> OFF, then RESET, then ACTIVE after 17 cycles.
- Link drop mid-RECOVER: local leaves operational_st during ch0 RECOVER -> link_up=0 next cycle, ch0 goes to OFF, relay_rst_n[0]=0, echo_rst[0]=1; retry_cnt is preserved.
- Simultaneous soft_rst[1] and relay_timeout[1] in ACTIVE -> soft_rst wins: RESET state; retry_cnt unchanged; timeout_cnt[1] unchanged.
- Async reset: reset_n low mid-RESET with CNT_W=4 and timeout_cnt=15 (saturated) -> all outputs return to reset values immediately, without waiting for a clock edge.
